// File: rtl/life_support_multi.sv
// Shared power/shield plus per-compartment O2/temperature with saturating updates and a
// latched fatal alarm. Define LS_POWER_DRAIN_EN for load-dependent power drain.
module life_support_multi #(
  parameter int unsigned W         = 16,
  parameter int unsigned NCH       = 4,
  parameter int unsigned TMAX      = 100,
  parameter int unsigned SH_MAX    = 100,
  parameter int unsigned ATK_DMG   = 5,
  parameter int unsigned ALARM_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ack,
  input  logic [3:0]       mode,
  input  logic             chrg,
  input  logic             atk,
  input  logic [W-1:0]     pwr_in,
  input  logic [W-1:0]     shield_in,
  input  logic [NCH*W-1:0] o2_in,
  input  logic [NCH-1:0]   o2sup,
  input  logic [NCH*W-1:0] temp_set,
  output logic [W-1:0]     outpower,
  output logic [W-1:0]     outshield,
  output logic [NCH*W-1:0] outo2,
  output logic [NCH*W-1:0] outtemp,
  output logic [NCH-1:0]   fatal,
  output logic             alarm,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StAlarm = 2'b10
  } state_e;

  localparam int unsigned CW = (ALARM_CNT < 1) ? 1 : $clog2(ALARM_CNT + 1);

  localparam logic [W-1:0]  VMax      = '1;
  localparam logic [W-1:0]  One       = W'(1);
  localparam logic [W-1:0]  TmaxV     = W'(TMAX);
  localparam logic [W-1:0]  ShMaxV    = W'(SH_MAX);
  localparam logic [W-1:0]  AtkDmgV   = W'(ATK_DMG);
  localparam logic [CW-1:0] CntMax    = '1;
  localparam logic [CW-1:0] CntOne    = CW'(1);
  localparam logic [CW-1:0] AlarmCntV = CW'(ALARM_CNT);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            power_q, power_d;
  logic [W-1:0]            shield_q, shield_d;
  logic [NCH-1:0][W-1:0]   o2_q, o2_d;
  logic [NCH-1:0][W-1:0]   temp_q, temp_d;

  logic [NCH-1:0]          fatal_c;
  logic                    any_fatal;
  logic                    pwr_nz;
  logic                    def_eff;
  logic                    sth_eff;
  logic [W-1:0]            drain;

  // Fatal flags are meaningless before the first load, so they are masked in IDLE.
  always_comb begin
    fatal_c = '0;
    for (int i = 0; i < NCH; i++) begin
      fatal_c[i] = (state_q != StIdle) && ((temp_q[i] >= TmaxV) || (o2_q[i] == '0));
    end
  end

  assign any_fatal = |fatal_c;
  assign pwr_nz    = (power_q != '0);
  assign def_eff   = pwr_nz && (mode == 4'b0100);
  assign sth_eff   = pwr_nz && (mode == 4'b1000);

`ifdef LS_POWER_DRAIN_EN
  always_comb begin
    drain = One;
    for (int i = 0; i < NCH; i++) begin
      drain = drain + W'(o2sup[i]);
    end
    if (def_eff) begin
      drain = drain + W'(2);
    end
  end
`else
  assign drain = One;
`endif

  // Datapath: every register updates in parallel from the current register values.
  always_comb begin
    power_d  = power_q;
    shield_d = shield_q;
    o2_d     = o2_q;
    temp_d   = temp_q;
    if (load) begin
      power_d  = pwr_in;
      shield_d = shield_in;
      for (int i = 0; i < NCH; i++) begin
        o2_d[i]   = o2_in[i*W +: W];
        temp_d[i] = temp_set[i*W +: W];
      end
    end else if (state_q != StIdle) begin
      if (chrg) begin
        power_d = pwr_in;
      end else begin
        power_d = (power_q > drain) ? (power_q - drain) : '0;
      end

      if (atk) begin
        shield_d = (shield_q > AtkDmgV) ? (shield_q - AtkDmgV) : '0;
      end else if (def_eff || (shield_q <= ShMaxV)) begin
        shield_d = (shield_q == VMax) ? VMax : (shield_q + One);
      end else begin
        shield_d = shield_q - One;
      end

      for (int i = 0; i < NCH; i++) begin
        if (o2sup[i]) begin
          o2_d[i] = o2_in[i*W +: W];
        end else begin
          o2_d[i] = (o2_q[i] != '0) ? (o2_q[i] - One) : '0;
        end

        if (sth_eff || (temp_set[i*W +: W] > temp_q[i])) begin
          temp_d[i] = (temp_q[i] == VMax) ? VMax : (temp_q[i] + One);
        end else if (temp_set[i*W +: W] < temp_q[i]) begin
          temp_d[i] = temp_q[i] - One;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (load) begin
          cnt_d = '0;
        end else begin
          if (any_fatal) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : (cnt_q + CntOne);
          end else begin
            cnt_d = '0;
          end
          if (cnt_d >= AlarmCntV) begin
            state_d = StAlarm;
            cnt_d   = '0;
          end
        end
      end
      StAlarm: begin
        cnt_d = '0;
        // An acknowledge is only honoured once every compartment is survivable.
        if (load || (ack && !any_fatal)) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      power_q  <= '0;
      shield_q <= '0;
      o2_q     <= '0;
      temp_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      power_q  <= power_d;
      shield_q <= shield_d;
      o2_q     <= o2_d;
      temp_q   <= temp_d;
    end
  end

  assign outpower  = power_q;
  assign outshield = shield_q;
  assign outo2     = o2_q;
  assign outtemp   = temp_q;
  assign fatal     = fatal_c;
  assign alarm     = (state_q == StAlarm);
  assign state     = state_q;

endmodule
